// File: rtl/cail_fft_ifft_feeder_pkg.sv
// Shared parameters, state encoding and sample type for the calibration
// FFT/IFFT feeder.
package cail_fft_ifft_feeder_pkg;

  localparam int FFT_LEN     = 512;
  localparam int DECIM       = 3;
  localparam int FIFO_DEPTH  = 2048;
  localparam int FILL_THRESH = 1500;
  localparam int MAX_FRAMES  = 6;
  localparam int CNT_SAT     = 30;

  localparam int DATA_W      = 48;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_CNT_W = 5;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cail_fft_ifft_feeder_sync_fifo_48.sv
// Single-clock 48-bit FIFO with registered read data, occupancy count and
// full/empty flags. Writes while full and reads while empty are discarded.
module sync_fifo_48
  import cail_fft_ifft_feeder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_300m,
  input  logic          locrstn,
  input  logic          wr_en_i,
  input  sample_t       wr_data_i,
  input  logic          rd_en_i,
  output sample_t       rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  sample_t         mem_q [DEPTH];
  sample_t         rd_data_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_fire;
  logic            rd_fire;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk_300m) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_300m or negedge locrstn) begin
    if (!locrstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (rd_fire) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/cail_fft_ifft_feeder.sv
// Calibration FFT/IFFT front end: decimates the DDS stream, buffers it and
// releases fixed-length AXI-Stream frames terminated by tlast.
module cail_fft_ifft_feeder
  import cail_fft_ifft_feeder_pkg::*;
(
  input  logic                   clk_300m,
  input  logic                   locrstn,
  input  logic [DATA_W-1:0]      s_dds_tdata,
  input  logic                   s_dds_tvalid,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [CNT_W-1:0]       wr_data_count,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]             state
);

  localparam int                     ISS_W     = $clog2(FFT_LEN) + 1;
  localparam int                     BEAT_W    = $clog2(FFT_LEN);
  localparam logic [1:0]             DEC_LAST  = 2'(DECIM - 1);
  localparam logic [ISS_W-1:0]       ISS_LEN   = ISS_W'(FFT_LEN);
  localparam logic [BEAT_W-1:0]      BEAT_LAST = BEAT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0]       FILL_LVL  = CNT_W'(FILL_THRESH);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LIM = FRAME_CNT_W'(MAX_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_SAT = FRAME_CNT_W'(CNT_SAT);

  logic [1:0]             cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  sample_t                wr_data_q, wr_data_d;
  state_e                 state_q, state_d;
  logic [ISS_W-1:0]       issued_q, issued_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic                   tvalid_q, tvalid_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   rd_en;
  logic                   hs;
  logic                   tlast;
  logic                   tlast_hs;
  logic                   in_read;
  sample_t                fifo_rd_data;
  logic                   fifo_full_w;
  logic                   fifo_empty_w;
  logic [CNT_W-1:0]       fifo_count;

  always_comb begin
    cnt_d     = (cnt_q == DEC_LAST) ? 2'd0 : cnt_q + 2'd1;
    wr_en_d   = (cnt_q == DEC_LAST) && s_dds_tvalid;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_data_d = s_dds_tdata;
    end
  end

  sync_fifo_48 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_300m  (clk_300m),
    .locrstn   (locrstn),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_data_q),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full_w),
    .empty_o   (fifo_empty_w),
    .count_o   (fifo_count)
  );

  assign in_read  = (state_q == ST_READ);
  assign hs       = tvalid_q && m_axis_tready;
  assign tlast    = tvalid_q && (beat_q == BEAT_LAST);
  assign tlast_hs = hs && tlast;
  // A new word may only enter the output register when it is empty or draining.
  assign rd_en    = in_read && (issued_q < ISS_LEN) && !fifo_empty_w &&
                    (!tvalid_q || m_axis_tready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if ((fifo_count >= FILL_LVL) && (frame_cnt_q <= FRAME_LIM)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (tlast_hs) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issued_d    = '0;
    beat_d      = '0;
    tvalid_d    = tvalid_q;
    frame_cnt_d = frame_cnt_q;
    if (in_read) begin
      issued_d = rd_en ? issued_q + 1'b1 : issued_q;
      beat_d   = hs ? beat_q + 1'b1 : beat_q;
    end
    if (rd_en) begin
      tvalid_d = 1'b1;
    end else if (hs) begin
      tvalid_d = 1'b0;
    end
    if (tlast_hs && (frame_cnt_q != FRAME_SAT)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_300m or negedge locrstn) begin
    if (!locrstn) begin
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      state_q     <= ST_IDLE;
      issued_q    <= '0;
      beat_q      <= '0;
      tvalid_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      state_q     <= state_d;
      issued_q    <= issued_d;
      beat_q      <= beat_d;
      tvalid_q    <= tvalid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_axis_tdata  = fifo_rd_data;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast;
  assign fifo_full     = fifo_full_w;
  assign fifo_empty    = fifo_empty_w;
  assign wr_data_count = fifo_count;
  assign frame_cnt     = frame_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cail_fft_ifft_feeder.sv
// Randomized bench for the FFT/IFFT feeder: a queue-based reference model of
// decimation, buffering and framing is compared against the DUT every cycle.
module tb_cail_fft_ifft_feeder;

  logic        clk_300m = 1'b0;
  logic        locrstn;
  logic [47:0] s_dds_tdata;
  logic        s_dds_tvalid;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        fifo_full;
  logic        fifo_empty;
  logic [11:0] wr_data_count;
  logic [4:0]  frame_cnt;
  logic [1:0]  state;

  cail_fft_ifft_feeder dut (
    .clk_300m      (clk_300m),
    .locrstn       (locrstn),
    .s_dds_tdata   (s_dds_tdata),
    .s_dds_tvalid  (s_dds_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .wr_data_count (wr_data_count),
    .frame_cnt     (frame_cnt),
    .state         (state)
  );

  always #2 clk_300m = ~clk_300m;

  int          n_checks;
  int          n_fail;

  // Reference model state
  logic [47:0] cap_q [$];
  int          written;
  int          hs_done;
  int          exp_occ;
  int          exp_prev;
  int          beat;
  int          frames;
  int          phase_m;
  int          post_seq;
  bit          d0, d1;
  bit          prev_stall;
  logic [47:0] prev_tdata;
  logic [1:0]  prev_state;
  logic [23:0] ramp;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cap_q.delete();
    written    = 0;
    hs_done    = 0;
    exp_occ    = 0;
    exp_prev   = 0;
    beat       = 0;
    frames     = 0;
    phase_m    = 0;
    post_seq   = 0;
    d0         = 1'b0;
    d1         = 1'b0;
    prev_stall = 1'b0;
    prev_tdata = '0;
    // Treat the reset as if the FSM just left DONE, so the next state must be IDLE.
    prev_state = 2'd3;
  endtask

  // One negedge: drive new inputs, then compare DUT against the model.
  task automatic step();
    logic [47:0] exp_d;
    s_dds_tdata   = {24'($urandom), ramp};
    ramp          = ramp + 24'd1;
    s_dds_tvalid  = ($urandom_range(0, 7) != 0);
    m_axis_tready = 1'($urandom_range(0, 1));

    // A captured sample is counted two cycles after capture; dropped when full.
    if (d1 && exp_prev < 2048) written++;
    d1 = d0;
    exp_occ = written - hs_done - int'(m_axis_tvalid);
    check_val("wr_data_count", 64'(wr_data_count), 64'(exp_occ));
    check_val("fifo_full", fifo_full, exp_occ == 2048);
    check_val("fifo_empty", fifo_empty, exp_occ == 0);

    if (prev_stall) begin
      check_val("hold_tvalid", m_axis_tvalid, 1'b1);
      check_val("hold_tdata", m_axis_tdata, prev_tdata);
    end

    if (post_seq != 0) begin
      case (post_seq)
        1:       check_val("seq_done", state, 2'd3);
        2:       check_val("seq_idle", state, 2'd0);
        default: check_val("seq_wait", state, 2'd1);
      endcase
      post_seq = (post_seq == 3) ? 0 : post_seq + 1;
    end else if (prev_state == 2'd3) begin
      check_val("done_exit", state, 2'd0);
    end else if (prev_state == 2'd0) begin
      check_val("idle_exit", state, 2'd1);
    end else if (prev_state == 2'd1) begin
      check_val("wait_exit", state, (exp_prev >= 1500 && frames < 6) ? 2'd2 : 2'd1);
    end

    check_val("frame_cnt", 64'(frame_cnt), 64'(frames));
    check_val("tlast", m_axis_tlast, m_axis_tvalid && beat == 511);
    if (frames >= 6) check_val("no_extra_beat", m_axis_tvalid, 1'b0);

    if (m_axis_tvalid && m_axis_tready) begin
      if (cap_q.size() == 0) begin
        check_val("beat_without_sample", 64'(cap_q.size()), 64'd1);
      end else begin
        exp_d = cap_q.pop_front();
        check_val("tdata", m_axis_tdata, exp_d);
      end
      hs_done++;
      beat++;
      if (beat == 512) begin
        beat     = 0;
        frames++;
        post_seq = 1;
        $display("frame %0d complete, %0d beats so far", frames, hs_done);
      end
    end

    if (phase_m == 2 && s_dds_tvalid) begin
      cap_q.push_back(s_dds_tdata);
      d0 = 1'b1;
    end else begin
      d0 = 1'b0;
    end
    phase_m = (phase_m + 1) % 3;

    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_tdata = m_axis_tdata;
    prev_state = state;
    exp_prev   = exp_occ;
  endtask

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_tvalid"}, m_axis_tvalid, 1'b0);
    check_val({phase, "_tlast"}, m_axis_tlast, 1'b0);
    check_val({phase, "_tdata"}, m_axis_tdata, 48'd0);
    check_val({phase, "_state"}, state, 2'd0);
    check_val({phase, "_frame_cnt"}, frame_cnt, 5'd0);
    check_val({phase, "_count"}, wr_data_count, 12'd0);
    check_val({phase, "_full"}, fifo_full, 1'b0);
  endtask

  initial begin
    int cyc;
    int tail;
    n_checks      = 0;
    n_fail        = 0;
    locrstn       = 1'b0;
    s_dds_tdata   = '0;
    s_dds_tvalid  = 1'b0;
    m_axis_tready = 1'b0;
    ramp          = '0;
    model_reset();

    repeat (4) @(negedge clk_300m);
    check_reset_outputs("por");
    locrstn = 1'b1;
    step();

    // Run into the first frame and abort it with a reset after 200 beats.
    cyc = 0;
    while (!(frames == 0 && beat == 200) && cyc < 20000) begin
      @(negedge clk_300m);
      step();
      cyc++;
    end
    check_val("reach_beat200", 64'(beat), 64'd200);

    @(negedge clk_300m);
    locrstn = 1'b0;
    #1;
    $display("reset pulsed mid-frame at beat %0d", beat);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk_300m);
    locrstn = 1'b1;
    model_reset();
    step();

    // Run until all frames are out and the FIFO has sat full for a while.
    cyc  = 0;
    tail = 0;
    while (tail < 300 && cyc < 70000) begin
      @(negedge clk_300m);
      step();
      cyc++;
      if (frames == 6 && exp_occ == 2048) tail++;
    end

    check_val("final_frame_cnt", frame_cnt, 5'd6);
    check_val("final_state", state, 2'd1);
    check_val("final_full", fifo_full, 1'b1);
    check_val("final_count", wr_data_count, 12'd2048);
    check_val("total_beats", 64'(hs_done), 64'd3072);
    $display("run ended after %0d cycles, %0d beats", cyc, hs_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
